// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add MUL/MULHU, restoring DIVU/REMU.
// One operation per start pulse, WIDTH iterations, registered result with a one-cycle done strobe.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on acceptance
// S_RUN  | one multiply/divide iteration per cycle, WIDTH cycles
// S_DONE | result valid, done high for this single cycle
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;

  // acc_hi holds the product high half or partial remainder;
  // acc_lo holds the multiplier/product low half or dividend/quotient.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, a_r};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, b_r});
    // when ge holds, shifted - b_r is below b_r, so WIDTH bits suffice
    diff    = shifted[WIDTH-1:0] - b_r;
    if (op_r[1]) begin
      hi_n = ge ? diff : shifted[WIDTH-1:0];
      lo_n = {acc_lo[WIDTH-2:0], ge};
    end else if (acc_lo[0]) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      hi_n = {1'b0, acc_hi[WIDTH-1:1]};
      lo_n = {acc_hi[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= op;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op[1] ? a : b;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // op[0] selects the high half (MULHU) or the remainder (REMU)
            result <= op_r[0] ? hi_n : lo_n;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: arithmetic reference model checked every cycle,
// plus directed operations with literal expected results and latencies.
module tb_muldiv_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (y == '0) ? '1 : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Timeline model: m_cnt = cycles since acceptance (0 = idle), done at WIDTH+1.
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_pend = '0;
  bit           m_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_on  = 1'b1;
      m_cnt = 0;
      m_res = '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  = 1;
        m_pend = ref_op(op, a, b);
      end
    end else if (m_cnt == W + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == W + 1) m_res = m_pend;
    end
    #1;
    if (m_on) begin
      check("cyc_busy", busy, 32'(m_cnt != 0));
      check("cyc_done", done, 32'(m_cnt == W + 1));
      check("cyc_result", result, 32'(m_res));
      if (done) done_pulses++;
    end
  end

  // Caller is positioned just after the acceptance edge (or the edge before it).
  task automatic wait_done(input string name, input int lat, input logic [W-1:0] expv);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 3 * W && !seen) begin
      @(posedge clk); #2;
      n++;
      if (done) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, 32'(result), 32'(expv));
    check({name, "_busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #2;
    check({name, "_done_low"}, 32'(done), 32'd0);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] expv, input bit scramble, input string name);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #2;
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      a = '0; b = '0; op = ~o;
    end
    wait_done(name, W, expv);
  endtask

  initial begin
    int p0;
    check("model_mul_max", 32'(ref_op(2'd0, 16'hFFFF, 16'hFFFF)), 32'h0001);
    check("model_mulhu_max", 32'(ref_op(2'd1, 16'hFFFF, 16'hFFFF)), 32'hFFFE);
    check("model_divu_zero", 32'(ref_op(2'd2, 16'h1234, 16'h0000)), 32'hFFFF);
    check("model_remu_zero", 32'(ref_op(2'd3, 16'h1234, 16'h0000)), 32'h1234);
    check("model_remu_100_7", 32'(ref_op(2'd3, 16'd100, 16'd7)), 32'd2);

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;

    run_op(2'd0, 16'd3, 16'd5, 16'h000F, 1'b0, "mul_3x5");

    // back-to-back with start held high through the first operation
    p0 = done_pulses;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #2;
    @(negedge clk);
    op = 2'd1;
    wait_done("b2b_mul", W, 16'h0001);
    wait_done("b2b_mulhu", W + 1, 16'hFFFE);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    #2;
    check("b2b_done_pulses", 32'(done_pulses - p0), 32'd2);

    run_op(2'd2, 16'd100, 16'd7, 16'd14, 1'b1, "divu_100_7");
    run_op(2'd3, 16'd100, 16'd7, 16'd2, 1'b1, "remu_100_7");
    run_op(2'd2, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, "divu_by_zero");
    run_op(2'd3, 16'h1234, 16'h0000, 16'h1234, 1'b0, "remu_by_zero");
    run_op(2'd0, 16'h1234, 16'h5678, 16'h0060, 1'b1, "mul_1234x5678");
    run_op(2'd1, 16'h1234, 16'h5678, 16'h0626, 1'b1, "mulhu_1234x5678");
    run_op(2'd2, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, "divu_ffff_1");
    run_op(2'd3, 16'd5, 16'd9, 16'd5, 1'b0, "remu_5_9");

    // reset abort at RUN iteration 5
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 16'h00FF; b = 16'h0101;
    @(posedge clk); #2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    p0 = done_pulses;
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 6) @(posedge clk);
    #2;
    check("abort_no_done", 32'(done_pulses - p0), 32'd0);

    // start held together with rst is accepted only once rst drops
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'd0; a = 16'd2; b = 16'd2;
    @(posedge clk); #2;
    check("rst_start_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    check("rst_start_accepted", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_2x2", W, 16'd4);

    // result hold
    run_op(2'd2, 16'd9, 16'd3, 16'd3, 1'b0, "divu_9_3");
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      check("hold_result", 32'(result), 32'd3);
      check("hold_done", 32'(done), 32'd0);
      check("hold_busy", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
